// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring supervisor: FSM states, seed value
// and the rotate helper that the monitor and its bench model both rely on.
package ring_pkg;

    localparam int MAX_WIDTH     = 32;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_CLEAR,
        ST_INJECT,
        ST_LOCKING,
        ST_LOCKED,
        ST_FAULT,
        ST_HALT
    } state_t;

    // Seed is the MSB alone; the ring then walks it down towards bit 0.
    function automatic logic [MAX_WIDTH-1:0] seed_of(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

    localparam logic [DEFAULT_WIDTH-1:0] SEED = 4'b1000;

    function automatic logic [MAX_WIDTH-1:0] ror1(input logic [MAX_WIDTH-1:0] v,
                                                  input int unsigned w);
        logic [MAX_WIDTH-1:0] r;
        r = v >> 1;
        if (v[0]) r = r | (MAX_WIDTH'(1) << (w - 1));
        return r;
    endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Bundle between the ring counter and its supervisor: ring sample in,
// re-seed controls and status out.
interface ring_monitor_if #(
    parameter int WIDTH       = 4,
    parameter int REV_W       = 8,
    parameter int FAULT_LIMIT = 3
);
    localparam int PHASE_W = $clog2(WIDTH);
    localparam int ERR_W   = $clog2(FAULT_LIMIT + 1);

    logic [WIDTH-1:0]   ring;
    logic               ring_clr;
    logic               inject;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               rev_tick;
    logic [REV_W-1:0]   rev_count;
    logic               locked;
    logic               fault;
    logic [ERR_W-1:0]   err_count;

    modport master (
        input  ring,
        output ring_clr, inject, phase, phase_valid, rev_tick,
               rev_count, locked, fault, err_count
    );

    modport slave (
        output ring,
        input  ring_clr, inject, phase, phase_valid, rev_tick,
               rev_count, locked, fault, err_count
    );

endinterface

// File: rtl/ring_onehot_check.sv
// Combinational one-hot classifier: flags exactly-one-set and all-zero and
// encodes the position of the set bit.
module ring_onehot_check #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             onehot,
    output logic             zero,
    output logic [IDX_W-1:0] index
);

    assign onehot = $onehot(vec);
    assign zero   = (vec == '0);

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ring_monitor.sv
// Supervisor for a one-hot ring counter: verifies stepping, reports phase and
// revolutions, and re-seeds the ring through clear/inject when it misbehaves.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int REV_W       = 8,
    parameter int LOCK_CYCLES = 4,
    parameter int FAULT_LIMIT = 3
) (
    input logic            clk,
    input logic            rst,
    ring_monitor_if.master bus
);

    localparam int PHASE_W = $clog2(WIDTH);
    localparam int ERR_W   = $clog2(FAULT_LIMIT + 1);
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0]    LOCK_FULL = LOCK_W'(LOCK_CYCLES);
    localparam logic [ERR_W-1:0]     ERR_MAX   = ERR_W'(FAULT_LIMIT);
    localparam logic [MAX_WIDTH-1:0] SEED_WORD = seed_of(WIDTH);
    localparam logic [WIDTH-1:0]     SEED_VAL  = SEED_WORD[WIDTH-1:0];

    state_t             state;
    logic [WIDTH-1:0]   ring_q;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [PHASE_W-1:0] phase_r;
    logic               phase_valid_r;
    logic               rev_tick_r;
    logic [REV_W-1:0]   rev_count_r;
    logic [ERR_W-1:0]   err_count_r;

    logic               onehot;
    logic               zero;
    logic [PHASE_W-1:0] index;
    logic               step_ok;
    logic               rev_hit;
    logic               good_sample;
    logic [ERR_W-1:0]   err_next;

    ring_onehot_check #(.WIDTH(WIDTH)) u_check (
        .vec    (bus.ring),
        .onehot (onehot),
        .zero   (zero),
        .index  (index)
    );

    // ring_q is zero-extended, so comparing full words keeps the upper bits quiet.
    assign step_ok     = onehot && !zero &&
                         (MAX_WIDTH'(bus.ring) == ror1(MAX_WIDTH'(ring_q), WIDTH));
    assign rev_hit     = step_ok && ring_q[0] && bus.ring[WIDTH-1];
    assign good_sample = (lock_cnt == '0) ? (bus.ring == SEED_VAL) : step_ok;
    assign err_next    = (err_count_r >= ERR_MAX) ? err_count_r : err_count_r + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RESET;
            ring_q        <= '0;
            lock_cnt      <= '0;
            phase_r       <= '0;
            phase_valid_r <= 1'b0;
            rev_tick_r    <= 1'b0;
            rev_count_r   <= '0;
            err_count_r   <= '0;
        end else begin
            ring_q        <= bus.ring;
            phase_valid_r <= 1'b0;
            rev_tick_r    <= 1'b0;
            case (state)
                ST_RESET:  state <= ST_CLEAR;
                ST_CLEAR:  state <= ST_INJECT;
                ST_INJECT: begin
                    state    <= ST_LOCKING;
                    lock_cnt <= '0;
                end
                ST_LOCKING: begin
                    if (!good_sample) begin
                        state       <= ST_FAULT;
                        err_count_r <= err_next;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state       <= ST_LOCKED;
                        lock_cnt    <= LOCK_FULL;
                        rev_count_r <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (step_ok) begin
                        phase_r       <= index;
                        phase_valid_r <= 1'b1;
                        if (rev_hit) begin
                            rev_tick_r  <= 1'b1;
                            rev_count_r <= rev_count_r + 1'b1;
                        end
                    end else begin
                        state       <= ST_FAULT;
                        err_count_r <= err_next;
                    end
                end
                ST_FAULT:  state <= (err_count_r >= ERR_MAX) ? ST_HALT : ST_CLEAR;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_RESET;
            endcase
        end
    end

    assign bus.ring_clr    = (state == ST_CLEAR);
    assign bus.inject      = (state == ST_INJECT);
    assign bus.locked      = (state == ST_LOCKED);
    assign bus.fault       = (state == ST_FAULT) || (state == ST_HALT);
    assign bus.phase       = phase_r;
    assign bus.phase_valid = phase_valid_r;
    assign bus.rev_tick    = rev_tick_r;
    assign bus.rev_count   = rev_count_r;
    assign bus.err_count   = err_count_r;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: an upstream ring model feeds the monitor while a
// sample-driven reference model predicts every output each cycle.
module tb_ring_monitor;
    import ring_pkg::*;

    localparam int W  = 4;
    localparam int RW = 8;
    localparam int LC = 4;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   stuck  = 1'b0;

    ring_monitor_if #(.WIDTH(W), .REV_W(RW), .FAULT_LIMIT(FL)) bus ();

    ring_monitor #(.WIDTH(W), .REV_W(RW), .LOCK_CYCLES(LC), .FAULT_LIMIT(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: boot counts the setup cycles left before samples are
    // judged, goodRun counts consecutive good samples since the seed arrived.
    int               boot      = 3;
    int               goodRun   = 0;
    int               errs      = 0;
    int               mPhase    = 0;
    int               mRev      = 0;
    bit               faulting  = 1'b0;
    bit               halted    = 1'b0;
    bit               mPv       = 1'b0;
    bit               mTick     = 1'b0;
    logic [W-1:0]     prevRing  = '0;

    function automatic bit isStep(input logic [W-1:0] prev, input logic [W-1:0] s);
        logic [31:0] r;
        r = ror1(32'(prev), W);
        return ($countones(s) == 1) && (32'(s) == r);
    endfunction

    function automatic int bitIndex(input logic [W-1:0] s);
        int k = 0;
        for (int i = 0; i < W; i++) if (s[i]) k = i;
        return k;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] sample;
        bit           bad;
        if (rst) begin
            boot = 3; goodRun = 0; errs = 0; mPhase = 0; mRev = 0;
            faulting = 1'b0; halted = 1'b0; mPv = 1'b0; mTick = 1'b0; prevRing = '0;
        end else begin
            sample = bus.ring;
            mPv    = 1'b0;
            mTick  = 1'b0;
            bad    = 1'b0;
            if (halted) begin
                bad = 1'b0;
            end else if (faulting) begin
                faulting = 1'b0;
                if (errs >= FL) halted = 1'b1;
                else boot = 2;
            end else if (boot > 0) begin
                boot--;
                goodRun = 0;
            end else if (goodRun < LC) begin
                if ((goodRun == 0) ? (sample == SEED) : isStep(prevRing, sample)) begin
                    goodRun++;
                    if (goodRun == LC) mRev = 0;
                end else begin
                    bad = 1'b1;
                end
            end else begin
                if (isStep(prevRing, sample)) begin
                    mPhase = bitIndex(sample);
                    mPv    = 1'b1;
                    if (prevRing[0] && sample[W-1]) begin
                        mTick = 1'b1;
                        mRev  = (mRev + 1) % (1 << RW);
                    end
                end else begin
                    bad = 1'b1;
                end
            end
            if (bad) begin
                faulting = 1'b1;
                goodRun  = 0;
                if (errs < FL) errs++;
            end
            prevRing = sample;
        end
    end

    function automatic logic [31:0] actVec();
        return {14'd0, bus.ring_clr, bus.inject, bus.locked, bus.fault, bus.phase_valid,
                bus.rev_tick, bus.phase, bus.rev_count, bus.err_count};
    endfunction

    function automatic logic [31:0] expVec();
        bit eClr, eInj, eLock, eFault;
        eClr   = !halted && !faulting && (boot == 2);
        eInj   = !halted && !faulting && (boot == 1);
        eLock  = !halted && !faulting && (boot == 0) && (goodRun == LC);
        eFault = faulting || halted;
        return {14'd0, eClr, eInj, eLock, eFault, mPv, mTick, 2'(mPhase), 8'(mRev), 2'(errs)};
    endfunction

    always @(negedge clk) begin
        checkOutput("outputs{clr,inj,lock,fault,pv,tick,phase,rev,err}", actVec(), expVec());
    end

    // Upstream ring: reacts at the edge to the clear/inject it saw during the cycle.
    task automatic applyStimulus(input bit overrideEn, input logic [W-1:0] overrideVal);
        logic        clrSeen;
        logic        injSeen;
        logic [31:0] rotated;
        clrSeen = bus.ring_clr;
        injSeen = bus.inject;
        @(posedge clk);
        #1;
        rotated = ror1(32'(bus.ring), W);
        if (overrideEn)   bus.ring = overrideVal;
        else if (stuck)   bus.ring = '0;
        else if (clrSeen) bus.ring = '0;
        else if (injSeen) bus.ring = SEED;
        else              bus.ring = rotated[W-1:0];
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus(1'b0, '0);
    endtask

    initial begin
        bus.ring = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", actVec(), 32'd0);
        rst = 1'b0;

        run(6);
        checkOutput("locked_before_7", 32'(bus.locked), 32'd0);
        run(1);
        checkOutput("locked_at_7", 32'(bus.locked), 32'd1);
        run(1);
        checkOutput("phase3_tick_rev1", {bus.phase_valid, bus.phase, bus.rev_tick, bus.rev_count},
                    {20'd0, 1'b1, 2'd3, 1'b1, 8'd1});
        for (int k = 2; k >= 0; k--) begin
            run(1);
            checkOutput("phase_seq", {bus.phase_valid, bus.phase, bus.rev_tick},
                        {28'd0, 1'b1, 2'(k), 1'b0});
        end

        run(1016);
        checkOutput("rev_255", 32'(bus.rev_count), 32'd255);
        run(1);
        checkOutput("rev_wrap", {bus.rev_tick, bus.rev_count}, {23'd0, 1'b1, 8'd0});

        applyStimulus(1'b1, 4'b1100);
        run(1);
        checkOutput("multihot_fault{fault,lock,pv,err}",
                    {bus.fault, bus.locked, bus.phase_valid, bus.err_count}, {27'd0, 3'b100, 2'd1});
        run(1);
        checkOutput("recover_clr{clr,inj}", {bus.ring_clr, bus.inject}, 32'b10);
        run(1);
        checkOutput("recover_inj{clr,inj}", {bus.ring_clr, bus.inject}, 32'b01);
        run(4);
        checkOutput("relock_pending", 32'(bus.locked), 32'd0);
        run(1);
        checkOutput("relock", 32'(bus.locked), 32'd1);

        run(3);
        checkOutput("pre_skip_rev", 32'(bus.rev_count), 32'd1);
        applyStimulus(1'b1, 4'b0100);
        run(1);
        checkOutput("skip_collision{fault,tick,rev,err}",
                    {bus.fault, bus.rev_tick, bus.rev_count, bus.err_count},
                    {20'd0, 1'b1, 1'b0, 8'd1, 2'd2});

        run(4);
        checkOutput("mid_locking{lock,fault}", {bus.locked, bus.fault}, 32'd0);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_locking", actVec(), 32'd0);
        @(negedge clk);
        bus.ring = '0;
        stuck    = 1'b1;
        rst      = 1'b0;

        for (int e = 1; e <= FL; e++) begin
            run(4);
            checkOutput("stuck_fault{fault,err}", {bus.fault, bus.err_count}, {29'd0, 1'b1, 2'(e)});
        end
        run(1);
        checkOutput("halt{fault,lock,clr,inj}", {bus.fault, bus.locked, bus.ring_clr, bus.inject},
                    32'b1000);
        for (int i = 0; i < 8; i++) begin
            run(1);
            checkOutput("halt_hold{fault,clr,inj}", {bus.fault, bus.ring_clr, bus.inject}, 32'b100);
        end

        #2 rst = 1'b1;
        #1 checkOutput("async_reset_halt", actVec(), 32'd0);
        @(negedge clk);
        bus.ring = '0;
        stuck    = 1'b0;
        rst      = 1'b0;
        run(6);
        checkOutput("restart_locked_before_7", 32'(bus.locked), 32'd0);
        run(1);
        checkOutput("restart_locked_at_7", 32'(bus.locked), 32'd1);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Downstream supervisor for the 4-stage one-hot ring counter. It samples the ring's parallel output every cycle, checks that exactly one bit is set and that it advances one position per clock (bit k to bit k-1, bit 0 wrapping to bit WIDTH-1). It encodes the active bit as a phase index and counts revolutions. When the ring is empty, multi-hot or mis-stepping, it drives the ring's reset and inject inputs to re-seed it.

## Interface
Parameters:
- WIDTH, 4, ring length; must be ≥ 2.
- REV_W, 8, revolution counter width.
- LOCK_CYCLES, 4, consecutive good samples required to declare lock.
- FAULT_LIMIT, 3, faults tolerated before halting.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ring  in  WIDTH  ring counter parallel output.
- ring_clr  out  1  synchronous clear to the ring's rst.
- inject  out  1  seed request to the ring's in.
- phase  out  clog2(WIDTH)  index of the active ring bit.
- phase_valid  out  1  phase is valid.
- rev_tick  out  1  one-cycle pulse per revolution.
- rev_count  out  REV_W  revolutions since lock; wraps.
- locked  out  1  state is LOCKED.
- fault  out  1  state is FAULT or HALT.
- err_count  out  clog2(FAULT_LIMIT+1)  faults seen; saturating.

## Operation
Internal signals:
- ring_q: registered copy of ring.
- onehot: ring has exactly one bit set.
- seed: the value 1 << (WIDTH-1).
- step_ok: onehot, and ring equals ring_q rotated right by one.

States (FSM):
- RESET: entered on reset. Goes to CLEAR on the next edge.
- CLEAR: ring_clr = 1 for one cycle, then INJECT.
- INJECT: inject = 1 for one cycle; the ring is all-zero here and is not checked. Then LOCKING with lock_cnt = 0.
- LOCKING:
  - While lock_cnt = 0, the sample is good only if ring == seed. Otherwise it is good if step_ok.
  - On a good sample, lock_cnt increments. The LOCK_CYCLES-th good sample moves the FSM to LOCKED, and rev_count clears to 0.
  - On any bad sample, go to FAULT.
- LOCKED: every cycle requires step_ok; otherwise go to FAULT.
- FAULT: lasts one cycle; err_count increments on entry. Next state is HALT if err_count has reached FAULT_LIMIT, else CLEAR.
- HALT: terminal; fault is held. Only rst exits.

Output decode and update rules:
- ring_clr and inject are Moore decodes of the state register.
- In LOCKED with step_ok, the edge sets phase to index(ring) and phase_valid to 1. Any other cycle clears phase_valid; phase holds its value.
- In LOCKED with step_ok, ring_q[0] = 1 and ring[WIDTH-1] = 1, the edge pulses rev_tick and increments rev_count (modulo 2^REV_W).
- A fault detected in the same cycle as a revolution wins: no rev_tick, no rev_count change, phase_valid goes to 0.

## Timing
- Reset values: all outputs 0, state RESET, ring_q 0, lock_cnt 0. Asserting rst forces these immediately, with no clock edge needed, from any state including mid-LOCKING or HALT.
- Recovery sequence from fault (ring_clr acts on the upstream ring at the next edge):
  - FAULT cycle.
  - CLEAR cycle: the ring clears at the edge ending it.
  - INJECT cycle: the ring loads seed at the edge ending it.
  - First LOCKING cycle sees seed.
- Minimum time from reset release to locked = 1 is 3 + LOCK_CYCLES edges.
- Fault reaction: a bad sample in cycle t gives fault = 1, locked = 0 and phase_valid = 0 in cycle t+1.
- Output latency: phase, phase_valid and rev_tick are registered, one cycle after the ring sample that produced them.
- Boundary behaviour:
  - err_count saturates at FAULT_LIMIT.
  - rev_count wraps to 0 silently.
  - lock_cnt never exceeds LOCK_CYCLES.

## Structure
- Shared package ring_pkg holds:
  - the FSM state encodings (RESET, CLEAR, INJECT, LOCKING, LOCKED, FAULT, HALT);
  - the seed constant;
  - a right-rotate-by-one function used by both this block and the bench model.
- Sub-module ring_onehot_check: combinational. Input is a WIDTH-bit vector; outputs are onehot, zero and a clog2(WIDTH) index. It is reused for both step checking and phase encoding.

## Test plan
Bench uses the upstream ring model with WIDTH=4, LOCK_CYCLES=4, FAULT_LIMIT=3, REV_W=8.
- **Clean start:** release rst.
  - FSM passes RESET, CLEAR, INJECT.
  - Ring reads 1000, 0100, 0010, 0001 during LOCKING.
  - locked = 1 on the following cycle.
  - phase reads 3, 2, 1, 0 with phase_valid = 1, each one cycle after its sample.
- **Revolution count:** in LOCKED, each 0001→1000 transition gives rev_tick high for exactly 1 cycle. rev_count reaches 1, 2, …, and after 256 revolutions reads 0.
- **Multi-hot:** force ring = 1100 for one cycle in LOCKED.
  - Next cycle: fault = 1, locked = 0, phase_valid = 0, err_count = 1.
  - Then ring_clr for 1 cycle, inject for 1 cycle, and re-lock after 4 good samples.
- **Skip plus revolution collision:** in LOCKED, drive 0001→0100. Required: fault, no rev_tick, rev_count unchanged.
- **Stuck ring:** model ignores ring_clr and inject and holds 0000. Required: three FAULT visits with err_count = 1, 2, 3, then HALT with fault = 1. inject and ring_clr stay 0 forever after.
- **Async reset:** assert rst between clock edges mid-LOCKING and in HALT. All outputs read 0 before the next edge. A clean start follows on release.
